// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-port arbiter in front of a single-ported data memory. Each port issues
//   one load or store at a time; the winner is latched, the memory is strobed
//   for exactly one cycle, and the port is answered with a one-cycle Ack
//   (plus Err when the address was rejected).
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no access in flight, arbitrate any raised request
//   ACCESS | latched access drives the memory bus (one cycle)
//   RESP   | Ack/Err to the winner; may grant the other port directly
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   Req/Write/Addr/WData 0,1   request side of each port
//   Ack/Err/RData 0,1          completion pulse, reject flag, last load data
//   MemRead/MemWrite           memory strobes (ACCESS only, legal only)
//   MemAddress/MemWriteData    memory bus, zero outside ACCESS
//   MemReadData                combinational read data from the memory
//   Busy                       high whenever the FSM is not in IDLE
module data_mem_arbiter #(
    parameter int unsigned MEM_WORDS      = 256,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        Write0,
    input  logic        Write1,
    input  logic [31:0] Addr0,
    input  logic [31:0] Addr1,
    input  logic [31:0] WData0,
    input  logic [31:0] WData1,
    output logic        Ack0,
    output logic        Ack1,
    output logic        Err0,
    output logic        Err1,
    output logic [31:0] RData0,
    output logic [31:0] RData1,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData,
    output logic        Busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // One bit wider than the address so large MEM_WORDS cannot overflow.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    logic [1:0]  state_q, state_d;
    logic        port_q, port_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        legal;
    logic        in_access;
    logic        in_resp;
    logic        grant_valid;
    logic        grant_port;

    assign legal     = (addr_q[1:0] == 2'b00) && ({1'b0, addr_q} < ADDR_LIMIT);
    assign in_access = (state_q == S_ACCESS);
    assign in_resp   = (state_q == S_RESP);

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        grant_valid  = 1'b0;
        grant_port   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req0 && Req1) begin
                    grant_valid = 1'b1;
                    grant_port  = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
                end else if (Req0 || Req1) begin
                    grant_valid = 1'b1;
                    grant_port  = Req1;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (!write_q) begin
                    if (port_q) rdata1_d = legal ? MemReadData : 32'd0;
                    else        rdata0_d = legal ? MemReadData : 32'd0;
                end
            end
            S_RESP: begin
                last_grant_d = port_q;
                state_d      = S_IDLE;
                // The acked port's Req is ignored here. Under fixed priority a
                // port-0 completion returns to IDLE instead of handing over, so
                // a still-requesting port 0 keeps winning there.
                if (!port_q) begin
                    if (Req1 && !FIXED_PRIORITY) begin
                        grant_valid = 1'b1;
                        grant_port  = 1'b1;
                    end
                end else if (Req0) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (grant_valid) begin
            state_d = S_ACCESS;
            port_d  = grant_port;
            write_d = grant_port ? Write1 : Write0;
            addr_d  = grant_port ? Addr1  : Addr0;
            wdata_d = grant_port ? WData1 : WData0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            port_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            last_grant_q <= 1'b1;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Bus outputs decode straight from state_q so reset kills them at once,
    // which keeps an interrupted store from committing.
    assign MemRead      = in_access && legal && !write_q;
    assign MemWrite     = in_access && legal && write_q;
    assign MemAddress   = in_access ? addr_q  : 32'd0;
    assign MemWriteData = in_access ? wdata_q : 32'd0;
    assign Ack0         = in_resp && !port_q;
    assign Ack1         = in_resp && port_q;
    assign Err0         = Ack0 && !legal;
    assign Err1         = Ack1 && !legal;
    assign RData0       = rdata0_q;
    assign RData1       = rdata1_q;
    assign Busy         = (state_q != S_IDLE);

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: word depth of the attached data memory; legal byte addresses are 0 to 4*MEM_WORDS-1.
REQ-002 SHALL have parameter FIXED_PRIORITY, default 0: 0 means round-robin, 1 means port 0 always wins ties.
REQ-003 SHALL have ports clk in 1, the single clock, and reset in 1, asynchronous active-high.
REQ-004 SHALL have ports Req0/Req1 in 1: request, held high with fields stable until the matching Ack.
REQ-005 SHALL have ports Write0/Write1 in 1: 1 = store, 0 = load.
REQ-006 SHALL have ports Addr0/Addr1 in 32 (byte address) and WData0/WData1 in 32 (store data).
REQ-007 SHALL have ports Ack0/Ack1 out 1: one-cycle completion pulse.
REQ-008 SHALL have ports Err0/Err1 out 1: pulses with Ack when the access was rejected.
REQ-009 SHALL have ports RData0/RData1 out 32: last load result of that port.
REQ-010 SHALL have ports MemRead, MemWrite out 1, and MemAddress, MemWriteData out 32: drive the data memory.
REQ-011 SHALL have port MemReadData in 32: combinational read data from the memory.
REQ-012 SHALL have port Busy out 1: high when state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, ACCESS, RESP.
REQ-014 IDLE: if any Req is high, SHALL pick a winner, latch its Write/Addr/WData and port id, and go to ACCESS; otherwise stay in IDLE.
REQ-015 Arbitration: single requester wins; on a tie with FIXED_PRIORITY=0, SHALL grant the port not granted last (LastGrant register); with FIXED_PRIORITY=1, SHALL grant port 0.
REQ-016 ACCESS (exactly 1 cycle): SHALL drive MemAddress and MemWriteData from the latched values, and assert MemWrite if a store or MemRead if a load, only when the access is legal.
REQ-017 ACCESS: on the closing edge, a load SHALL capture MemReadData into RData of the winning port; a store commits in the memory on the same edge. SHALL go to RESP.
REQ-018 RESP (exactly 1 cycle): SHALL assert Ack of the winner, plus Err if illegal, and update LastGrant.
REQ-019 RESP next state: if the non-acked port has Req high, SHALL arbitrate it directly and go to ACCESS; otherwise go to IDLE. The acked port's Req SHALL be ignored during RESP.
REQ-020 Latency: Req seen in IDLE at cycle t gives memory strobe at t+1 and Ack at t+2. Back-to-back grants to alternating ports SHALL sustain one access per 2 cycles.
REQ-021 Illegal access: Addr[1:0] != 0, or Addr >= 4*MEM_WORDS.
REQ-022 Illegal access SHALL NOT assert MemRead or MemWrite; a load SHALL set RData to 0; it SHALL still complete with Ack and Err.
REQ-023 MemRead and MemWrite SHALL be low in every state except ACCESS, and never high together.
REQ-024 MemAddress and MemWriteData SHALL be 0 outside ACCESS.
REQ-025 RData of a port SHALL hold its value until that port's next load completes; stores SHALL NOT change RData.
REQ-026 Ack0 and Ack1 SHALL never be high in the same cycle.
REQ-027 Req dropped before Ack (protocol violation) SHALL NOT abort an already-latched access.

Reset
REQ-028 reset high SHALL immediately force state IDLE; Ack0/1, Err0/1, MemRead, MemWrite, Busy, MemAddress, MemWriteData = 0; RData0/1 = 0; LastGrant = 1, so port 0 wins the first tie.
REQ-029 reset asserted during ACCESS SHALL drop MemWrite asynchronously so that no write commits; the in-flight request SHALL receive no Ack.
REQ-030 After reset deasserts, arbitration SHALL resume on the first rising edge.

Verification
REQ-031 Port 0 stores 0xDEADBEEF at 0x10, then loads 0x10 -> MemWrite high 1 cycle at t+1; second Ack0 with RData0=0xDEADBEEF, Err0=0.
REQ-032 Req0 and Req1 both held for 4 transactions, FIXED_PRIORITY=0 -> Acks alternate 0,1,0,1, one Ack every 2 cycles.
REQ-033 Same stimulus with FIXED_PRIORITY=1 -> all Acks go to port 0 while Req0 stays high; port 1 is served only after Req0 drops.
REQ-034 Port 1 loads 0x402 (misaligned), then 0x400 (out of range, MEM_WORDS=256) -> MemRead never asserted; Ack1 and Err1 both high; RData1=0.
REQ-035 reset pulsed during ACCESS of a store of 0x12345678 to 0x20 -> no Ack; a later load from 0x20 returns the old value; all outputs zero while reset is high.
